id_ex_buffer: RTL



---
 rtl/id_ex_buffer.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_buffer.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_buffer
// Description : ID/EX pipeline register for the 5-stage core. Captures the
//               decoded fields and control signals from ID once per cycle
//               and presents them to EX. It also:
//                 - inserts a bubble (all-zero EX fields) on a load-use
//                   stall from the HDU or a taken-branch flush from EX;
//                 - holds everything unchanged on a global freeze;
//                 - counts accepted stall and flush cycles (saturating);
//                 - raises a sticky error when stalls are accepted on two
//                   consecutive accepted cycles.
//               Edge action priority: rst > flush > freeze > stall > load.
//
// Ports       : clk, rst                 clock, synchronous active-high reset
//               HDU_stall_in             load-use stall request
//               flush_in                 taken-branch flush from EX
//               freeze_in                global freeze (memory busy)
//               *_ID_in                  decoded fields / control from ID
//               *_EX_out                 registered EX-stage copies
//               stall_cnt_out            accepted stall cycles (saturating)
//               flush_cnt_out            accepted flush cycles (saturating)
//               stall_err_out            sticky back-to-back stall flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_buffer #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,

    // Pipeline control
    input  logic              HDU_stall_in,
    input  logic              flush_in,
    input  logic              freeze_in,

    // Decode-stage inputs
    input  logic              valid_ID_in,
    input  logic [3:0]        inst_opcode_ID_in,
    input  logic [2:0]        Rdst_ID_in,
    input  logic [2:0]        Rsrc_ID_in,
    input  logic [DATA_W-1:0] Rdst_data_ID_in,
    input  logic [DATA_W-1:0] Rsrc_data_ID_in,
    input  logic [DATA_W-1:0] imm_ID_in,
    input  logic [PC_W-1:0]   pc_ID_in,
    input  logic              mem_read_ID_in,
    input  logic              mem_write_ID_in,
    input  logic              reg_write_ID_in,
    input  logic [3:0]        alu_op_ID_in,

    // Execute-stage outputs
    output logic              valid_EX_out,
    output logic [3:0]        inst_opcode_EX_out,
    output logic [2:0]        Rdst1_EX_out,
    output logic [2:0]        Rsrc_EX_out,
    output logic [DATA_W-1:0] Rdst_data_EX_out,
    output logic [DATA_W-1:0] Rsrc_data_EX_out,
    output logic [DATA_W-1:0] imm_EX_out,
    output logic [PC_W-1:0]   pc_EX_out,
    output logic              mem_read_EX_out,
    output logic              mem_write_EX_out,
    output logic              reg_write_EX_out,
    output logic [3:0]        alu_op_EX_out,

    // Event monitoring
    output logic [CNT_W-1:0]  stall_cnt_out,
    output logic [CNT_W-1:0]  flush_cnt_out,
    output logic              stall_err_out
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic              r_valid;
    logic [3:0]        r_opcode;
    logic [2:0]        r_rdst;
    logic [2:0]        r_rsrc;
    logic [DATA_W-1:0] r_rdst_data;
    logic [DATA_W-1:0] r_rsrc_data;
    logic [DATA_W-1:0] r_imm;
    logic [PC_W-1:0]   r_pc;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_reg_write;
    logic [3:0]        r_alu_op;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              r_stall_err;
    // Set only by an accepted stall; any accepted flush or load clears it,
    // a freeze leaves it alone so a stall-freeze-stall run still counts as
    // back-to-back.
    logic              r_prev_stall;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic              w_valid_nxt;
    logic [3:0]        w_opcode_nxt;
    logic [2:0]        w_rdst_nxt;
    logic [2:0]        w_rsrc_nxt;
    logic [DATA_W-1:0] w_rdst_data_nxt;
    logic [DATA_W-1:0] w_rsrc_data_nxt;
    logic [DATA_W-1:0] w_imm_nxt;
    logic [PC_W-1:0]   w_pc_nxt;
    logic              w_mem_read_nxt;
    logic              w_mem_write_nxt;
    logic              w_reg_write_nxt;
    logic [3:0]        w_alu_op_nxt;
    logic [CNT_W-1:0]  w_stall_cnt_nxt;
    logic [CNT_W-1:0]  w_flush_cnt_nxt;
    logic              w_stall_err_nxt;
    logic              w_prev_stall_nxt;

    // ------------------------------------------------------------------
    // Action decode: exactly one of these is high every cycle. Reset is
    // not part of this decode; it overrides everything in the flop block.
    // ------------------------------------------------------------------
    logic w_act_flush;
    logic w_act_freeze;
    logic w_act_stall;
    logic w_act_load;

    always_comb begin
        w_act_flush  = flush_in;
        w_act_freeze = !flush_in && freeze_in;
        w_act_stall  = !flush_in && !freeze_in && HDU_stall_in;
        w_act_load   = !flush_in && !freeze_in && !HDU_stall_in;
    end

    // Saturating increments; at all-ones the counter stays put.
    logic [CNT_W-1:0] w_stall_cnt_inc;
    logic [CNT_W-1:0] w_flush_cnt_inc;

    always_comb begin
        w_stall_cnt_inc = (r_stall_cnt == c_CNT_MAX) ? r_stall_cnt
                                                     : r_stall_cnt + c_CNT_ONE;
        w_flush_cnt_inc = (r_flush_cnt == c_CNT_MAX) ? r_flush_cnt
                                                     : r_flush_cnt + c_CNT_ONE;
    end

    // ------------------------------------------------------------------
    // Pipeline payload next-state. Default is hold (freeze); a bubble is
    // all zeros, which also makes the opcode a NOP and drops mem_read so
    // the HDU cannot re-trigger on the inserted bubble.
    // ------------------------------------------------------------------
    always_comb begin
        w_valid_nxt     = r_valid;
        w_opcode_nxt    = r_opcode;
        w_rdst_nxt      = r_rdst;
        w_rsrc_nxt      = r_rsrc;
        w_rdst_data_nxt = r_rdst_data;
        w_rsrc_data_nxt = r_rsrc_data;
        w_imm_nxt       = r_imm;
        w_pc_nxt        = r_pc;
        w_mem_read_nxt  = r_mem_read;
        w_mem_write_nxt = r_mem_write;
        w_reg_write_nxt = r_reg_write;
        w_alu_op_nxt    = r_alu_op;

        if (w_act_flush || w_act_stall) begin
            w_valid_nxt     = 1'b0;
            w_opcode_nxt    = 4'd0;
            w_rdst_nxt      = 3'd0;
            w_rsrc_nxt      = 3'd0;
            w_rdst_data_nxt = '0;
            w_rsrc_data_nxt = '0;
            w_imm_nxt       = '0;
            w_pc_nxt        = '0;
            w_mem_read_nxt  = 1'b0;
            w_mem_write_nxt = 1'b0;
            w_reg_write_nxt = 1'b0;
            w_alu_op_nxt    = 4'd0;
        end else if (w_act_load) begin
            // valid=0 from ID passes straight through; ID owns zeroing its
            // own control fields for non-instructions.
            w_valid_nxt     = valid_ID_in;
            w_opcode_nxt    = inst_opcode_ID_in;
            w_rdst_nxt      = Rdst_ID_in;
            w_rsrc_nxt      = Rsrc_ID_in;
            w_rdst_data_nxt = Rdst_data_ID_in;
            w_rsrc_data_nxt = Rsrc_data_ID_in;
            w_imm_nxt       = imm_ID_in;
            w_pc_nxt        = pc_ID_in;
            w_mem_read_nxt  = mem_read_ID_in;
            w_mem_write_nxt = mem_write_ID_in;
            w_reg_write_nxt = reg_write_ID_in;
            w_alu_op_nxt    = alu_op_ID_in;
        end
    end

    // ------------------------------------------------------------------
    // Event counters, prev-stall tracking and sticky error next-state
    // ------------------------------------------------------------------
    always_comb begin
        w_stall_cnt_nxt  = r_stall_cnt;
        w_flush_cnt_nxt  = r_flush_cnt;
        w_stall_err_nxt  = r_stall_err;
        w_prev_stall_nxt = r_prev_stall;

        if (w_act_flush) begin
            w_flush_cnt_nxt  = w_flush_cnt_inc;
            w_prev_stall_nxt = 1'b0;
        end else if (w_act_stall) begin
            w_stall_cnt_nxt  = w_stall_cnt_inc;
            w_stall_err_nxt  = r_stall_err | r_prev_stall;
            w_prev_stall_nxt = 1'b1;
        end else if (w_act_load) begin
            w_prev_stall_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_opcode     <= 4'd0;
            r_rdst       <= 3'd0;
            r_rsrc       <= 3'd0;
            r_rdst_data  <= '0;
            r_rsrc_data  <= '0;
            r_imm        <= '0;
            r_pc         <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_alu_op     <= 4'd0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_stall_err  <= 1'b0;
            r_prev_stall <= 1'b0;
        end else begin
            r_valid      <= w_valid_nxt;
            r_opcode     <= w_opcode_nxt;
            r_rdst       <= w_rdst_nxt;
            r_rsrc       <= w_rsrc_nxt;
            r_rdst_data  <= w_rdst_data_nxt;
            r_rsrc_data  <= w_rsrc_data_nxt;
            r_imm        <= w_imm_nxt;
            r_pc         <= w_pc_nxt;
            r_mem_read   <= w_mem_read_nxt;
            r_mem_write  <= w_mem_write_nxt;
            r_reg_write  <= w_reg_write_nxt;
            r_alu_op     <= w_alu_op_nxt;
            r_stall_cnt  <= w_stall_cnt_nxt;
            r_flush_cnt  <= w_flush_cnt_nxt;
            r_stall_err  <= w_stall_err_nxt;
            r_prev_stall <= w_prev_stall_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs are straight flop copies; no input reaches an output
    // combinationally.
    // ------------------------------------------------------------------
    assign valid_EX_out       = r_valid;
    assign inst_opcode_EX_out = r_opcode;
    assign Rdst1_EX_out       = r_rdst;
    assign Rsrc_EX_out        = r_rsrc;
    assign Rdst_data_EX_out   = r_rdst_data;
    assign Rsrc_data_EX_out   = r_rsrc_data;
    assign imm_EX_out         = r_imm;
    assign pc_EX_out          = r_pc;
    assign mem_read_EX_out    = r_mem_read;
    assign mem_write_EX_out   = r_mem_write;
    assign reg_write_EX_out   = r_reg_write;
    assign alu_op_EX_out      = r_alu_op;
    assign stall_cnt_out      = r_stall_cnt;
    assign flush_cnt_out      = r_flush_cnt;
    assign stall_err_out      = r_stall_err;

endmodule
`default_nettype wire
